// File: rtl/mips_pkg.sv
// Shared constants for the register-file write path.
//   DATA_WIDTH / REGFILE_WIDTH : default datapath and register-address widths
//   REG_ZERO                   : hard-wired zero register address
//   REQ_WB / REQ_MD / REQ_DBG  : bit positions of each requester in grant vectors
package mips_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int REGFILE_WIDTH = 5;

  localparam logic [REGFILE_WIDTH-1:0] REG_ZERO = '0;

  localparam int REQ_WB  = 0;
  localparam int REQ_MD  = 1;
  localparam int REQ_DBG = 2;
  localparam int NUM_REQ = 3;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per register marking a pending mult/div result.
//   clk, reset       : clock, async active-low reset (clears all busy bits)
//   set_en/set_addr  : mark a register busy (MD issue); address 0 ignored
//   clr_en/clr_addr  : clear a register (MD result accepted)
//   rs_addr/rt_addr  : decode lookups
//   rs_busy/rt_busy  : current-state busy bits, no same-cycle bypass
module reg_scoreboard #(
  parameter int REGFILE_WIDTH = mips_pkg::REGFILE_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [REGFILE_WIDTH-1:0] set_addr,
  input  logic                     clr_en,
  input  logic [REGFILE_WIDTH-1:0] clr_addr,
  input  logic [REGFILE_WIDTH-1:0] rs_addr,
  input  logic [REGFILE_WIDTH-1:0] rt_addr,
  output logic                     rs_busy,
  output logic                     rt_busy
);

  localparam int NREG = 1 << REGFILE_WIDTH;
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    set_mask = set_en ? (ONE << set_addr) : '0;
    clr_mask = clr_en ? (ONE << clr_addr) : '0;
    // Set applied after clear: a fresh issue to the same register stays pending.
    // Bit 0 is masked so $zero can never look busy.
    busy_nxt = ((busy & ~clr_mask) | set_mask) & ~ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign rs_busy = busy[rs_addr];
  assign rt_busy = busy[rt_addr];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-bank write port among pipeline write-back
// (WB), the mult/div unit (MD) and the debug/loader port (DBG), and keeps the
// MD-pending scoreboard used by decode for RAW stalls.
//   clk, reset                 : clock, async active-low reset
//   wb_valid/addr/data         : WB request; wb_stall tells the pipeline to freeze
//   md_issue/md_issue_addr     : MD issue, marks destination busy
//   md_valid/addr/data, md_ready : MD result handshake
//   dbg_valid/addr/data, dbg_ready : debug write handshake
//   rs_addr/rt_addr -> rs_busy/rt_busy : scoreboard lookups
//   we/addressW/data           : registered write port, one cycle after grant
module regfile_write_arbiter #(
  parameter int DATA_WIDTH    = mips_pkg::DATA_WIDTH,
  parameter int REGFILE_WIDTH = mips_pkg::REGFILE_WIDTH,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [REGFILE_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     wb_stall,
  input  logic                     md_issue,
  input  logic [REGFILE_WIDTH-1:0] md_issue_addr,
  input  logic                     md_valid,
  input  logic [REGFILE_WIDTH-1:0] md_addr,
  input  logic [DATA_WIDTH-1:0]    md_data,
  output logic                     md_ready,
  input  logic                     dbg_valid,
  input  logic [REGFILE_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0]    dbg_data,
  output logic                     dbg_ready,
  input  logic [REGFILE_WIDTH-1:0] rs_addr,
  input  logic [REGFILE_WIDTH-1:0] rt_addr,
  output logic                     rs_busy,
  output logic                     rt_busy,
  output logic                     we,
  output logic [REGFILE_WIDTH-1:0] addressW,
  output logic [DATA_WIDTH-1:0]    data
);

  import mips_pkg::REQ_WB;
  import mips_pkg::REQ_MD;
  import mips_pkg::REQ_DBG;
  import mips_pkg::NUM_REQ;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [3:0]               starve_cnt;
  logic                     force_md;
  logic [NUM_REQ-1:0]       gnt;
  logic                     any_gnt;
  logic [REGFILE_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;

  assign force_md = md_valid && (starve_cnt >= STARVE_LIM);

  // Grants are gated by reset so nothing is consumed while the block is held.
  always_comb begin
    gnt = '0;
    if (reset) begin
      if (force_md)       gnt[REQ_MD]  = 1'b1;
      else if (wb_valid)  gnt[REQ_WB]  = 1'b1;
      else if (md_valid)  gnt[REQ_MD]  = 1'b1;
      else if (dbg_valid) gnt[REQ_DBG] = 1'b1;
    end
  end

  assign any_gnt   = |gnt;
  assign wb_stall  = wb_valid && force_md;
  assign md_ready  = gnt[REQ_MD];
  assign dbg_ready = gnt[REQ_DBG];

  always_comb begin
    sel_addr = wb_addr;
    sel_data = wb_data;
    if (gnt[REQ_MD]) begin
      sel_addr = md_addr;
      sel_data = md_data;
    end else if (gnt[REQ_DBG]) begin
      sel_addr = dbg_addr;
      sel_data = dbg_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!md_valid || gnt[REQ_MD]) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Writes to $zero are consumed but never enable the bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we       <= 1'b0;
      addressW <= '0;
      data     <= '0;
    end else if (any_gnt) begin
      we       <= (sel_addr != '0);
      addressW <= sel_addr;
      data     <= sel_data;
    end else begin
      we <= 1'b0;
    end
  end

  reg_scoreboard #(
    .REGFILE_WIDTH(REGFILE_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (md_issue),
    .set_addr (md_issue_addr),
    .clr_en   (md_ready),
    .clr_addr (md_addr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_issue;
  logic [4:0]  md_issue_addr;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic        dbg_valid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        we;
  logic [4:0]  addressW;
  logic [31:0] data;

  int vectors = 0;
  int miscompares = 0;

  regfile_write_arbiter #(
    .DATA_WIDTH(32),
    .REGFILE_WIDTH(5),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .md_issue(md_issue), .md_issue_addr(md_issue_addr),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .we(we), .addressW(addressW), .data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Requester-side stability: addr/data held while a handshake request waits.
  logic        md_wait, dbg_wait;
  logic [4:0]  md_addr_q, dbg_addr_q;
  logic [31:0] md_data_q, dbg_data_q;
  initial begin
    md_wait = 1'b0;
    dbg_wait = 1'b0;
  end
  always @(posedge clk) begin
    if (reset && md_wait && md_valid) begin
      assert (md_addr === md_addr_q && md_data === md_data_q) else begin
        miscompares++;
        $error("FAIL md_hold: observed %0h/%0h expected %0h/%0h", md_addr, md_data, md_addr_q, md_data_q);
      end
    end
    if (reset && dbg_wait && dbg_valid) begin
      assert (dbg_addr === dbg_addr_q && dbg_data === dbg_data_q) else begin
        miscompares++;
        $error("FAIL dbg_hold: observed %0h/%0h expected %0h/%0h", dbg_addr, dbg_data, dbg_addr_q, dbg_data_q);
      end
    end
    md_wait    = reset && md_valid && !md_ready;
    md_addr_q  = md_addr;
    md_data_q  = md_data;
    dbg_wait   = reset && dbg_valid && !dbg_ready;
    dbg_addr_q = dbg_addr;
    dbg_data_q = dbg_data;
  end

  initial begin
    reset = 1'b0;
    wb_valid = 1'b1;  wb_addr = 5'd5;  wb_data = 32'hDEADBEEF;
    md_valid = 1'b1;  md_addr = 5'd4;  md_data = 32'hA4;
    dbg_valid = 1'b1; dbg_addr = 5'd6; dbg_data = 32'hA6;
    md_issue = 1'b0;  md_issue_addr = 5'd0;
    rs_addr = 5'd8;   rt_addr = 5'd9;

    // Held in reset with every requester asserting
    tick; tick;
    check("rst_we", we, 0);
    check("rst_addressW", addressW, 0);
    check("rst_data", data, 0);
    check("rst_md_ready", md_ready, 0);
    check("rst_dbg_ready", dbg_ready, 0);
    check("rst_wb_stall", wb_stall, 0);
    check("rst_rs_busy", rs_busy, 0);
    check("rst_rt_busy", rt_busy, 0);

    // Release: WB wins first
    reset = 1'b1;
    #1;
    check("rel_wb_stall", wb_stall, 0);
    check("rel_md_ready", md_ready, 0);
    check("rel_dbg_ready", dbg_ready, 0);
    tick;
    check("wb5_we", we, 1);
    check("wb5_addressW", addressW, 5);
    check("wb5_data", data, 32'hDEADBEEF);

    // Priority: WB > MD > DBG
    wb_addr = 5'd3; wb_data = 32'hA3;
    #1;
    check("pri_wb_md_ready", md_ready, 0);
    check("pri_wb_dbg_ready", dbg_ready, 0);
    check("pri_wb_stall", wb_stall, 0);
    tick;
    check("pri_wb_addressW", addressW, 3);
    check("pri_wb_data", data, 32'hA3);
    wb_valid = 1'b0;
    #1;
    check("pri_md_ready", md_ready, 1);
    check("pri_md_dbg_ready", dbg_ready, 0);
    tick;
    check("pri_md_addressW", addressW, 4);
    check("pri_md_data", data, 32'hA4);
    md_valid = 1'b0;
    #1;
    check("pri_dbg_ready", dbg_ready, 1);
    tick;
    check("pri_dbg_addressW", addressW, 6);
    check("pri_dbg_data", data, 32'hA6);
    dbg_valid = 1'b0;
    tick;
    check("idle_we", we, 0);
    check("idle_addressW_hold", addressW, 6);

    // DBG alone
    dbg_valid = 1'b1; dbg_addr = 5'd31; dbg_data = 32'h1;
    #1;
    check("dbg31_ready", dbg_ready, 1);
    tick;
    check("dbg31_we", we, 1);
    check("dbg31_addressW", addressW, 31);
    check("dbg31_data", data, 32'h1);
    dbg_valid = 1'b0;

    // Starvation: MD loses 4 cycles, forced on the 5th
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hB10;
    md_valid = 1'b1; md_addr = 5'd11; md_data = 32'hC11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("starve_md_ready", md_ready, 0);
      check("starve_wb_stall", wb_stall, 0);
      tick;
      check("starve_wb_addressW", addressW, 10);
    end
    #1;
    check("force_md_ready", md_ready, 1);
    check("force_wb_stall", wb_stall, 1);
    tick;
    check("force_we", we, 1);
    check("force_addressW", addressW, 11);
    check("force_data", data, 32'hC11);
    md_addr = 5'd13; md_data = 32'hC13;
    #1;
    check("resume_wb_stall", wb_stall, 0);
    check("resume_md_ready", md_ready, 0);
    tick;
    check("resume_addressW", addressW, 10);
    wb_valid = 1'b0; md_valid = 1'b0;
    tick;

    // Scoreboard set / clear / set-wins
    md_issue = 1'b1; md_issue_addr = 5'd8; rs_addr = 5'd8; rt_addr = 5'd9;
    #1;
    check("sb_no_bypass", rs_busy, 0);
    tick;
    md_issue = 1'b0;
    #1;
    check("sb_rs8_busy", rs_busy, 1);
    check("sb_rt9_idle", rt_busy, 0);
    md_valid = 1'b1; md_addr = 5'd8; md_data = 32'h88;
    #1;
    check("sb_md8_ready", md_ready, 1);
    check("sb_rs8_still", rs_busy, 1);
    tick;
    check("sb_rs8_cleared", rs_busy, 0);
    check("sb_md8_addressW", addressW, 8);
    md_valid = 1'b0;
    md_issue = 1'b1; md_issue_addr = 5'd9;
    tick;
    md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h99;
    #1;
    check("sb_rt9_busy", rt_busy, 1);
    check("sb_md9_ready", md_ready, 1);
    tick;
    md_issue = 1'b0; md_valid = 1'b0;
    #1;
    check("sb_set_wins", rt_busy, 1);
    check("sb_md9_addressW", addressW, 9);

    // $zero
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
    #1;
    check("zero_wb_stall", wb_stall, 0);
    tick;
    check("zero_we", we, 0);
    wb_valid = 1'b0;
    md_issue = 1'b1; md_issue_addr = 5'd0; rs_addr = 5'd0;
    tick;
    md_issue = 1'b0;
    #1;
    check("zero_rs_busy", rs_busy, 0);

    // Async reset mid-cycle
    md_issue = 1'b1; md_issue_addr = 5'd8;
    wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h12;
    tick;
    md_issue = 1'b0; wb_valid = 1'b0; rs_addr = 5'd8;
    #1;
    check("pre_rst_rs_busy", rs_busy, 1);
    check("pre_rst_we", we, 1);
    check("pre_rst_addressW", addressW, 12);
    #3 reset = 1'b0;
    #1;
    check("arst_rs_busy", rs_busy, 0);
    check("arst_rt_busy", rt_busy, 0);
    check("arst_we", we, 0);
    check("arst_addressW", addressW, 0);
    check("arst_data", data, 0);
    tick;
    reset = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
